sub16_serial: RTL and testbench
===============================

Name: sub16_serial

Overview:
- Bit-serial, multi-cycle subtractor. Computes diff = a - b - b_in and a borrow-out over WIDTH clock cycles, one bit per cycle, LSB first.
- It is the inverse-operation companion to the combinational 16-bit ripple-carry adder.
- It is used where area matters more than latency.
- A start/ready/done handshake lets an adder-based datapath or a self-checking bench recover operands, e.g. (sum - b - c_in) == a.

Parameters:
WIDTH, 16, operand/result width in bits (≥2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
b_in  input  1  borrow-in; captured on accepted start
ready  output  1  high in IDLE only; start is accepted when start & ready
done  output  1  single-cycle pulse; diff/b_out valid
diff  output  WIDTH  result a - b - b_in mod 2^WIDTH; held until next accepted start
b_out  output  1  borrow-out (1 when a < b + b_in as unsigned); held with diff

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces the following, regardless of clk:
  - state=IDLE, ready=1, done=0;
  - diff=0, b_out=0;
  - operand shift registers, borrow flop and bit counter all 0.
- Reset mid-RUN abandons the operation. No done pulse is produced. Deassertion returns to IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready=1. If start=1 at edge k:
    - latch a→sa, b→sb, b_in→br;
    - clear cnt;
    - go to RUN.
  - RUN: ready=0. Each edge:
    - d = sa[0] ^ sb[0] ^ br;
    - br ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    - sa, sb shift right one bit;
    - d shifts into the result register MSB-side, so after WIDTH shifts bit 0 is at diff[0];
    - cnt increments.
    - The edge that processes bit WIDTH-1 (edge k+WIDTH) transfers the result register to diff, br to b_out, and moves to DONE.
  - DONE: done=1 for exactly one cycle, ready=0. Next edge goes to IDLE.
- Latency: start accepted at edge k → done=1 and diff/b_out valid after edge k+WIDTH. ready=1 again after edge k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- diff and b_out change only on the RUN→DONE edge (or reset). They are stable and readable indefinitely afterwards.
- start=1 while ready=0 is ignored: no queuing, and in-flight operands are unaffected.
- start held high continuously: the next operation is accepted on the first IDLE edge.
- a, b, b_in changing after acceptance has no effect.
- Arithmetic is unsigned mod 2^WIDTH.
  - b_out=1 iff a < b + b_in, with the comparison done at WIDTH+1 bits.
  - Edge case: a=b=0, b_in=1 → diff = all ones, b_out=1.
- cnt width is $clog2(WIDTH). RUN→DONE exit is at cnt==WIDTH-1, so there is no wrap-around reliance.

Decomposition:
- Shared package sub16_pkg:
  - state enum type (IDLE, RUN, DONE);
  - default WIDTH constant;
  - counter width function/constant.
- One natural sub-module: fs1, a combinational 1-bit full subtractor (x, y, bin → d, bout). It is instantiated once in the serial datapath.
- The bench reuses fs1 only indirectly: the reference model is a - b - b_in at WIDTH+1 bits.

Test Plan:
1. Reset, then start with a=20, b=9, b_in=0 → done pulse exactly 16 cycles after acceptance; diff=11, b_out=0; ready low throughout RUN/DONE.
2. a=0, b=1, b_in=0 → diff=16'hffff, b_out=1. Then a=16'hffff, b=16'hffff, b_in=1 → diff=16'hffff, b_out=1. Then a=16'hffff, b=0, b_in=0 → diff=16'hffff, b_out=0.
3. a=57687, b=40398, b_in=0 → diff=17289, b_out=0. Then a=14152, b=50398, b_in=1 → diff=29289, b_out=1 (inverse of adder cases).
4. Accept a=100, b=1; pulse start with a=5, b=5 at cycle 3 of RUN → ignored; result diff=99, b_out=0; exactly one done pulse.
5. Accept an operation, drop rst_n asynchronously mid-cycle at RUN count 7 → ready=1, done=0, diff=0, b_out=0 immediately. After release, a=0, b=0, b_in=1 → diff=16'hffff, b_out=1.
6. start held high for 3 back-to-back ops (1-0, 2-1, 3-3) → done pulses 18 cycles apart; diff=1, 1, 0; b_out=0 each; diff stable between pulses.

Source files
------------

// File: rtl/sub16_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding, default operand width and bit-counter width helper.
package sub16_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/sub16_serial_if.sv
// Start/ready/done handshake and operand/result bus of the serial subtractor.
// master drives the request; slave is the subtractor.
interface sub16_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;

  modport master (
    output start, a, b, b_in,
    input  ready, done, diff, b_out
  );

  modport slave (
    input  start, a, b, b_in,
    output ready, done, diff, b_out
  );
endinterface

// File: rtl/sub16_serial_fs1.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
// Latency 0; no handshake.
module fs1 (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
endmodule

// File: rtl/sub16_serial.sv
// Bit-serial subtractor: diff = a - b - b_in over WIDTH cycles, LSB first.
// Latency WIDTH cycles to done; start ignored unless ready (no queuing).
module sub16_serial
  import sub16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  sub16_serial_if.slave bus
);
  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             br_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;

  logic             diff_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  fs1 u_fs1 (
    .x_i    (sa_q[0]),
    .y_i    (sb_q[0]),
    .bin_i  (br_q),
    .d_o    (diff_bit),
    .bout_o (br_d)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 lands at res[0].
  assign res_d = {diff_bit, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && ready_q) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            br_q    <= bus.b_in;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.b_out = bout_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial: driver pushes expected results on accept,
// monitor pops and checks on every done pulse.
module tb_sub16_serial;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sub16_serial_if #(.WIDTH(16)) bus ();
  sub16_serial #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] last_diff = '0;
  logic        last_bout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (bus.done) begin
        check("ready_low_in_done", 32'(bus.ready), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("diff", 32'(bus.diff), 32'(e.diff));
          check("b_out", 32'(bus.b_out), 32'(e.bout));
          check("done_latency", 32'(cyc), 32'(e.acc + 16));
        end
        last_diff = bus.diff;
        last_bout = bus.b_out;
      end else begin
        check("result_held", {15'd0, bus.b_out, bus.diff}, {15'd0, last_bout, last_diff});
        if (sb_q.size() != 0 && cyc >= sb_q[0].acc && cyc < sb_q[0].acc + 16)
          check("ready_low_in_run", 32'(bus.ready), 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic bin, output int acc);
    wait_ready();
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.b_in  = bin;
    @(posedge clk);
    #1;
    acc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                    input logic [15:0] ed, input logic eb);
    int acc;
    accept(a, b, bin, acc);
    sb_q.push_back('{ed, eb, acc});
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.b_in  = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.b_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. basic
    op(16'd20, 16'd9, 1'b0, 16'd11, 1'b0);
    // 2. boundaries
    op(16'd0, 16'd1, 1'b0, 16'hffff, 1'b1);
    op(16'hffff, 16'hffff, 1'b1, 16'hffff, 1'b1);
    op(16'hffff, 16'd0, 1'b0, 16'hffff, 1'b0);
    // 3. inverse of adder cases
    op(16'd57687, 16'd40398, 1'b0, 16'd17289, 1'b0);
    op(16'd14152, 16'd50398, 1'b1, 16'd29289, 1'b1);

    // 4. start during RUN is ignored
    accept(16'd100, 16'd1, 1'b0, acc);
    sb_q.push_back('{16'd99, 1'b0, acc});
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd5;
    bus.b     = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    // 5. asynchronous reset mid-RUN
    accept(16'h1234, 16'h0001, 1'b0, acc);
    repeat (7) @(posedge clk);
    #2;
    check("run_ready_low", 32'(bus.ready), 32'd0);
    rst_n = 1'b0;
    sb_q.delete();
    last_diff = '0;
    last_bout = 1'b0;
    #1;
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_diff", 32'(bus.diff), 32'd0);
    check("arst_bout", 32'(bus.b_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(16'd0, 16'd0, 1'b1, 16'hffff, 1'b1);

    // 6. start held high: back-to-back ops 18 cycles apart
    wait_ready();
    bus.start = 1'b1;
    bus.a     = 16'd1;
    bus.b     = 16'd0;
    bus.b_in  = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    sb_q.push_back('{16'd1, 1'b0, acc});
    sb_q.push_back('{16'd1, 1'b0, acc + 18});
    sb_q.push_back('{16'd0, 1'b0, acc + 36});
    @(negedge clk);
    bus.a = 16'd2;
    bus.b = 16'd1;
    repeat (18) @(negedge clk);
    bus.a = 16'd3;
    bus.b = 16'd3;
    repeat (18) @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
